// File: rtl/stack_if.sv
// Push/pop bus for stack_unit. When STACK_CLR_EN is defined the bus also carries clr.
interface stack_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 10
) ();
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic [AW-1:0]    sp;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
`ifdef STACK_CLR_EN
  logic             clr;

  modport master (
    output push, pop, din, clr,
    input  dout, dout_vld, sp, count, empty, full, ovf, unf
  );
  modport slave (
    input  push, pop, din, clr,
    output dout, dout_vld, sp, count, empty, full, ovf, unf
  );
`else
  modport master (
    output push, pop, din,
    input  dout, dout_vld, sp, count, empty, full, ovf, unf
  );
  modport slave (
    input  push, pop, din,
    output dout, dout_vld, sp, count, empty, full, ovf, unf
  );
`endif
endinterface

// File: rtl/stack_unit.sv
// Downward-growing LIFO stack, all state on negedge clk, 1-cycle registered pop data.
// Optional synchronous clear is enabled by defining STACK_CLR_EN.
module stack_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 10
) (
  input logic    clk,
  input logic    rst,
  stack_if.slave bus
);
  localparam int unsigned DEPTH     = 1 << AW;
  localparam logic [AW:0] CountFull = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    sp_q, sp_d, sp_top, waddr;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             empty, full, we, clr;

`ifdef STACK_CLR_EN
  assign clr = bus.clr;
`else
  assign clr = 1'b0;
`endif

  assign empty  = (count_q == '0);
  assign full   = (count_q == CountFull);
  // sp points at the next free slot, so the current top lives one above it.
  assign sp_top = sp_q + 1'b1;

  always_comb begin
    sp_d       = sp_q;
    count_d    = count_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    we         = 1'b0;
    waddr      = sp_q;
    if (clr) begin
      sp_d    = '1;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case ({bus.push, bus.pop})
        2'b10: begin
          if (!full) begin
            we      = 1'b1;
            sp_d    = sp_q - 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        2'b01: begin
          if (!empty) begin
            dout_d     = mem[sp_top];
            sp_d       = sp_top;
            count_d    = count_q - 1'b1;
            dout_vld_d = 1'b1;
          end else begin
            unf_d = 1'b1;
          end
        end
        2'b11: begin
          dout_vld_d = 1'b1;
          if (!empty) begin
            // Swap: the read sees the old top because the write is non-blocking.
            dout_d = mem[sp_top];
            we     = 1'b1;
            waddr  = sp_top;
          end else begin
            dout_d = bus.din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (we && rst) begin
      mem[waddr] <= bus.din;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      sp_q       <= '1;
      count_q    <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      count_q    <= count_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.sp       = sp_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: reset, LIFO order, overflow, underflow, swap, async reset.
module tb_stack_unit;
  logic clk = 1'b1;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  stack_if #(.WIDTH(32), .AW(10)) bus ();

  stack_unit #(.WIDTH(32), .AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive one operation in the high phase, sample just after the negedge that consumes it.
  task automatic cyc(input logic p, input logic q, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.push = p;
    bus.pop  = q;
    bus.din  = d;
    @(negedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_checks++; if (bus.sp !== 10'h3FF) begin n_fail++; $display("FAIL reset_sp: got %0h want 3ff", bus.sp); end
    n_checks++; if (bus.count !== 11'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", bus.dout_vld); end
    n_checks++; if (bus.dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %0h want 0", bus.dout); end
    n_checks++; if ({bus.ovf, bus.unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {bus.ovf, bus.unf}); end
    #1 rst = 1'b1;
  endtask

  task automatic test_lifo();
    logic [31:0] exp_vals [3];
    exp_vals = '{32'hC, 32'hB, 32'hA};
    pulse_reset();
    cyc(1'b1, 1'b0, 32'hA);
    cyc(1'b1, 1'b0, 32'hB);
    cyc(1'b1, 1'b0, 32'hC);
    n_checks++; if (bus.sp !== 10'h3FC) begin n_fail++; $display("FAIL lifo_sp3: got %0h want 3fc", bus.sp); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 32'h0);
      n_checks++; if (bus.dout !== exp_vals[i]) begin n_fail++; $display("FAIL lifo_dout%0d: got %0h want %0h", i, bus.dout, exp_vals[i]); end
      n_checks++; if (bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL lifo_vld%0d: got %b want 1", i, bus.dout_vld); end
    end
    cyc(1'b0, 1'b0, 32'h0);
    n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL lifo_vld_drop: got %b want 0", bus.dout_vld); end
    n_checks++; if (bus.dout !== 32'hA) begin n_fail++; $display("FAIL lifo_dout_hold: got %0h want a", bus.dout); end
    n_checks++; if (bus.sp !== 10'h3FF) begin n_fail++; $display("FAIL lifo_sp: got %0h want 3ff", bus.sp); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty: got %b want 1", bus.empty); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int i = 0; i < 1024; i++) cyc(1'b1, 1'b0, 32'(i));
    n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", bus.full); end
    n_checks++; if (bus.sp !== 10'h3FF) begin n_fail++; $display("FAIL ovf_sp: got %0h want 3ff", bus.sp); end
    n_checks++; if (bus.count !== 11'd1024) begin n_fail++; $display("FAIL ovf_count: got %0d want 1024", bus.count); end
    n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", bus.ovf); end
    cyc(1'b1, 1'b0, 32'hDEAD);
    n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.ovf); end
    n_checks++; if (bus.count !== 11'd1024) begin n_fail++; $display("FAIL ovf_count2: got %0d want 1024", bus.count); end
    cyc(1'b0, 1'b1, 32'h0);
    n_checks++; if (bus.dout !== 32'd1023) begin n_fail++; $display("FAIL ovf_pop: got %0d want 1023", bus.dout); end
    n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf); end
  endtask

  task automatic test_underflow();
    pulse_reset();
    cyc(1'b0, 1'b1, 32'h0);
    n_checks++; if (bus.unf !== 1'b1) begin n_fail++; $display("FAIL unf_flag: got %b want 1", bus.unf); end
    n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL unf_vld: got %b want 0", bus.dout_vld); end
    n_checks++; if (bus.sp !== 10'h3FF) begin n_fail++; $display("FAIL unf_sp: got %0h want 3ff", bus.sp); end
    n_checks++; if (bus.count !== 11'd0) begin n_fail++; $display("FAIL unf_count: got %0d want 0", bus.count); end
    cyc(1'b1, 1'b0, 32'h5);
    cyc(1'b0, 1'b1, 32'h0);
    n_checks++; if (bus.dout !== 32'h5) begin n_fail++; $display("FAIL unf_pop: got %0h want 5", bus.dout); end
    n_checks++; if (bus.unf !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got %b want 1", bus.unf); end
  endtask

  task automatic test_swap();
    pulse_reset();
    cyc(1'b1, 1'b0, 32'h1);
    cyc(1'b1, 1'b0, 32'h2);
    cyc(1'b1, 1'b1, 32'h9);
    n_checks++; if (bus.dout !== 32'h2) begin n_fail++; $display("FAIL swap_dout: got %0h want 2", bus.dout); end
    n_checks++; if (bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL swap_vld: got %b want 1", bus.dout_vld); end
    n_checks++; if (bus.count !== 11'd2) begin n_fail++; $display("FAIL swap_count: got %0d want 2", bus.count); end
    n_checks++; if (bus.sp !== 10'h3FD) begin n_fail++; $display("FAIL swap_sp: got %0h want 3fd", bus.sp); end
    cyc(1'b0, 1'b1, 32'h0);
    n_checks++; if (bus.dout !== 32'h9) begin n_fail++; $display("FAIL swap_pop1: got %0h want 9", bus.dout); end
    cyc(1'b0, 1'b1, 32'h0);
    n_checks++; if (bus.dout !== 32'h1) begin n_fail++; $display("FAIL swap_pop2: got %0h want 1", bus.dout); end
    pulse_reset();
    cyc(1'b1, 1'b1, 32'h7);
    n_checks++; if (bus.dout !== 32'h7) begin n_fail++; $display("FAIL pass_dout: got %0h want 7", bus.dout); end
    n_checks++; if (bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL pass_vld: got %b want 1", bus.dout_vld); end
    n_checks++; if (bus.count !== 11'd0) begin n_fail++; $display("FAIL pass_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.unf !== 1'b0) begin n_fail++; $display("FAIL pass_unf: got %b want 0", bus.unf); end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    cyc(1'b1, 1'b0, 32'h11);
    cyc(1'b1, 1'b0, 32'h22);
    cyc(1'b1, 1'b0, 32'h33);
    cyc(1'b0, 1'b1, 32'h0);
    n_checks++; if (bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL arst_pre_vld: got %b want 1", bus.dout_vld); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (bus.count !== 11'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.sp !== 10'h3FF) begin n_fail++; $display("FAIL arst_sp: got %0h want 3ff", bus.sp); end
    n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld: got %b want 0", bus.dout_vld); end
    rst = 1'b1;
  endtask

`ifdef STACK_CLR_EN
  task automatic test_clr();
    pulse_reset();
    cyc(1'b1, 1'b0, 32'h11);
    cyc(1'b1, 1'b0, 32'h22);
    cyc(1'b1, 1'b0, 32'h33);
    cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    bus.clr  = 1'b1;
    bus.push = 1'b1;
    bus.din  = 32'hBEEF;
    @(negedge clk);
    #1;
    bus.clr  = 1'b0;
    bus.push = 1'b0;
    n_checks++; if (bus.count !== 11'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.sp !== 10'h3FF) begin n_fail++; $display("FAIL clr_sp: got %0h want 3ff", bus.sp); end
    n_checks++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL clr_vld: got %b want 0", bus.dout_vld); end
    n_checks++; if (bus.dout !== 32'h22) begin n_fail++; $display("FAIL clr_dout_hold: got %0h want 22", bus.dout); end
    n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty: got %b want 1", bus.empty); end
  endtask
`endif

  initial begin
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = '0;
`ifdef STACK_CLR_EN
    bus.clr  = 1'b0;
`endif
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_swap();
    test_async_reset();
`ifdef STACK_CLR_EN
    test_clr();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
